robo_atuador: RTL and testbench
===============================

Name: robo_atuador

Overview:
- Actuator sequencer directly downstream of the robot navigation FSM.
- Consumes the FSM's one-hot command outputs `avancar`, `girar` and `recolher_entulho`, and turns each accepted command into a timed drive sequence for the wheel motor, turn motor, arm and gripper.
- Reports busy/done status and counts commands discarded while a sequence is running.

Parameters:
- T_AVANCO, 8, clock cycles `motor_frente` is driven per accepted `avancar` (must be >= 1)
- T_GIRO, 4, clock cycles `motor_giro` is driven per accepted `girar` (>= 1)
- T_BRACO, 3, clock cycles per arm travel, down or up (>= 1)
- T_GARRA, 2, clock cycles the gripper closes at the bottom position (>= 1)
- CNT_W, 8, width of the phase counter; all T_* values must be <= 2^CNT_W

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (reset = 0 resets)
- avancar  in  1  forward command from the navigation FSM
- girar  in  1  rotate command from the navigation FSM
- recolher_entulho  in  1  debris-collect command from the navigation FSM
- motor_frente  out  1  forward wheel drive
- motor_giro  out  1  rotation drive
- braco_descer  out  1  arm lowering drive
- braco_subir  out  1  arm raising drive
- garra_fechar  out  1  gripper close
- ocupado  out  1  high whenever a sequence is active
- concluido  out  1  one-cycle pulse when a sequence finishes
- erro_cmd  out  1  one-cycle pulse when more than one command bit is high at an accepting edge
- descartados  out  8  saturating count of cycles with a command present while busy

Behaviour:
- All outputs are registered.
- Reset (reset = 0, asynchronous): state IDLE, counter 0, every output 0, `descartados` 0. Reset mid-sequence drops all drives on assertion, with no completion pulse.
- States: IDLE, AVANCO, GIRO, DESCE, AGARRA, SOBE.
- Commands are sampled on the rising edge; the source FSM updates on the falling edge, so inputs are stable at the sample point.
- IDLE acceptance:
  - Priority `recolher_entulho` > `girar` > `avancar`.
  - The accepted command moves the state to DESCE / GIRO / AVANCO at that edge. The drive output is high from the next cycle (1-cycle latency).
  - If 2 or more command bits are high, `erro_cmd` pulses for 1 cycle and the highest-priority command is still accepted.
  - No command present: stay in IDLE.
- Phase timing: on entry to each phase the counter loads T-1. It decrements each cycle, and the phase exits on the edge where the counter is 0. Each phase therefore lasts exactly T cycles.
- Phase sequencing:
  - AVANCO: `motor_frente`=1 for T_AVANCO cycles, then IDLE.
  - GIRO: `motor_giro`=1 for T_GIRO cycles, then IDLE.
  - DESCE: `braco_descer`=1 for T_BRACO cycles, then AGARRA.
  - AGARRA: `garra_fechar`=1 for T_GARRA cycles, then SOBE.
  - SOBE: `braco_subir`=1 and `garra_fechar`=1 for T_BRACO cycles, then IDLE.
  - A full collect sequence therefore takes 2*T_BRACO + T_GARRA cycles.
- Status outputs:
  - `ocupado` = 1 in every non-IDLE state.
  - `concluido` = 1 in the first IDLE cycle after any sequence ends.
  - A command sampled at the edge closing that cycle is accepted, so the minimum gap between sequences is 1 idle cycle.
- Busy-time commands:
  - Any command bit high at an edge while not in IDLE is ignored, including the edge that exits the last phase.
  - `descartados` increments by 1 per such edge and saturates at 255.
  - It is cleared only by reset.
- Mutual exclusion: at most one of `motor_frente`, `motor_giro`, `braco_descer`, `braco_subir` is high in any cycle; `braco_descer` and `braco_subir` are never high together.

Test Plan:
- Reset held low, then released with no commands → all outputs 0 and `ocupado`=0 indefinitely. Assert reset during SOBE → all outputs 0 immediately, no `concluido` pulse.
- `avancar` for 1 cycle → `motor_frente`=1 for exactly 8 cycles starting 1 cycle later, `ocupado` matches those 8 cycles, then `concluido`=1 for 1 cycle.
- `recolher_entulho` for 1 cycle → `braco_descer` for 3 cycles, `garra_fechar` alone for 2 cycles, `braco_subir` with `garra_fechar` for 3 cycles (8 total), then `concluido`.
- `girar` and `avancar` high in the same IDLE cycle → `erro_cmd` pulses once, `motor_giro` for 4 cycles, `motor_frente` never asserts.
- `girar` accepted, then `avancar` held high continuously → `descartados`=4 (counting through the exit edge), `concluido` pulse, then `avancar` accepted at the next edge and `motor_frente` runs 8 cycles.
- Keep commands asserted through 300 busy edges → `descartados` saturates at 255 and does not wrap.

Source files
------------

// File: rtl/robo_atuador_if.sv
// Command and actuator bundle between the navigation FSM and the actuator sequencer.
interface robo_atuador_if;
    logic       avancar;
    logic       girar;
    logic       recolher_entulho;
    logic       motor_frente;
    logic       motor_giro;
    logic       braco_descer;
    logic       braco_subir;
    logic       garra_fechar;
    logic       ocupado;
    logic       concluido;
    logic       erro_cmd;
    logic [7:0] descartados;

    // Navigation FSM side: issues commands, observes drives and status.
    modport master (
        output avancar, girar, recolher_entulho,
        input  motor_frente, motor_giro, braco_descer, braco_subir, garra_fechar,
        input  ocupado, concluido, erro_cmd, descartados
    );

    // Actuator side: consumes commands, produces drives and status.
    modport slave (
        input  avancar, girar, recolher_entulho,
        output motor_frente, motor_giro, braco_descer, braco_subir, garra_fechar,
        output ocupado, concluido, erro_cmd, descartados
    );
endinterface

// File: rtl/robo_atuador.sv
// Actuator sequencer: turns one-hot navigation commands into timed motor,
// arm and gripper drive sequences, with busy/done status and a saturating
// count of commands that arrive while a sequence is running.
module robo_atuador #(
    parameter int T_AVANCO = 8,
    parameter int T_GIRO   = 4,
    parameter int T_BRACO  = 3,
    parameter int T_GARRA  = 2,
    parameter int CNT_W    = 8
) (
    input  logic           clock,
    input  logic           reset,
    robo_atuador_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_AVANCO = 3'd1,
        S_GIRO   = 3'd2,
        S_DESCE  = 3'd3,
        S_AGARRA = 3'd4,
        S_SOBE   = 3'd5
    } state_t;

    // Counter reload values: a phase lasting T cycles starts at T-1 and exits at 0.
    localparam logic [CNT_W-1:0] L_AVANCO = CNT_W'(T_AVANCO - 1);
    localparam logic [CNT_W-1:0] L_GIRO   = CNT_W'(T_GIRO - 1);
    localparam logic [CNT_W-1:0] L_BRACO  = CNT_W'(T_BRACO - 1);
    localparam logic [CNT_W-1:0] L_GARRA  = CNT_W'(T_GARRA - 1);
    localparam logic [CNT_W-1:0] L_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] L_ONE    = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;

    logic       r_motor_frente, r_motor_giro, r_braco_descer, r_braco_subir, r_garra_fechar;
    logic       r_ocupado, r_concluido, r_erro_cmd;
    logic [7:0] r_descartados;

    logic       w_motor_frente, w_motor_giro, w_braco_descer, w_braco_subir, w_garra_fechar;
    logic       w_ocupado, w_concluido, w_erro_cmd;
    logic [7:0] w_descartados;

    logic       w_cmd_any;
    logic       w_cmd_multi;
    logic       w_phase_end;

    assign w_cmd_any   = bus.avancar | bus.girar | bus.recolher_entulho;
    assign w_cmd_multi = (bus.avancar & bus.girar) | (bus.avancar & bus.recolher_entulho)
                       | (bus.girar & bus.recolher_entulho);
    assign w_phase_end = (r_cnt == L_ZERO);

    // State register and phase counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= L_ZERO;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: command acceptance in IDLE, phase sequencing elsewhere.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.recolher_entulho) begin
                    w_state_next = S_DESCE;
                    w_cnt_next   = L_BRACO;
                end else if (bus.girar) begin
                    w_state_next = S_GIRO;
                    w_cnt_next   = L_GIRO;
                end else if (bus.avancar) begin
                    w_state_next = S_AVANCO;
                    w_cnt_next   = L_AVANCO;
                end else begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = L_ZERO;
                end
            end
            S_AVANCO, S_GIRO, S_SOBE: begin
                if (w_phase_end) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = L_ZERO;
                end else begin
                    w_cnt_next   = r_cnt - L_ONE;
                end
            end
            S_DESCE: begin
                if (w_phase_end) begin
                    w_state_next = S_AGARRA;
                    w_cnt_next   = L_GARRA;
                end else begin
                    w_cnt_next   = r_cnt - L_ONE;
                end
            end
            S_AGARRA: begin
                if (w_phase_end) begin
                    w_state_next = S_SOBE;
                    w_cnt_next   = L_BRACO;
                end else begin
                    w_cnt_next   = r_cnt - L_ONE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = L_ZERO;
            end
        endcase
    end

    // Output decode from the upcoming state so drives line up with the registered state.
    always_comb begin
        w_motor_frente = 1'b0;
        w_motor_giro   = 1'b0;
        w_braco_descer = 1'b0;
        w_braco_subir  = 1'b0;
        w_garra_fechar = 1'b0;
        case (w_state_next)
            S_AVANCO: w_motor_frente = 1'b1;
            S_GIRO:   w_motor_giro   = 1'b1;
            S_DESCE:  w_braco_descer = 1'b1;
            S_AGARRA: w_garra_fechar = 1'b1;
            S_SOBE: begin
                w_braco_subir  = 1'b1;
                w_garra_fechar = 1'b1;
            end
            default: begin
                w_motor_frente = 1'b0;
            end
        endcase
        w_ocupado   = (w_state_next != S_IDLE);
        w_concluido = (r_state != S_IDLE) && (w_state_next == S_IDLE);
        w_erro_cmd  = (r_state == S_IDLE) && w_cmd_multi;
        // Any command seen while busy is dropped and counted, saturating at full scale.
        if ((r_state != S_IDLE) && w_cmd_any && (r_descartados != 8'hFF)) begin
            w_descartados = r_descartados + 8'd1;
        end else begin
            w_descartados = r_descartados;
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_motor_frente <= 1'b0;
            r_motor_giro   <= 1'b0;
            r_braco_descer <= 1'b0;
            r_braco_subir  <= 1'b0;
            r_garra_fechar <= 1'b0;
            r_ocupado      <= 1'b0;
            r_concluido    <= 1'b0;
            r_erro_cmd     <= 1'b0;
            r_descartados  <= 8'd0;
        end else begin
            r_motor_frente <= w_motor_frente;
            r_motor_giro   <= w_motor_giro;
            r_braco_descer <= w_braco_descer;
            r_braco_subir  <= w_braco_subir;
            r_garra_fechar <= w_garra_fechar;
            r_ocupado      <= w_ocupado;
            r_concluido    <= w_concluido;
            r_erro_cmd     <= w_erro_cmd;
            r_descartados  <= w_descartados;
        end
    end

    assign bus.motor_frente = r_motor_frente;
    assign bus.motor_giro   = r_motor_giro;
    assign bus.braco_descer = r_braco_descer;
    assign bus.braco_subir  = r_braco_subir;
    assign bus.garra_fechar = r_garra_fechar;
    assign bus.ocupado      = r_ocupado;
    assign bus.concluido    = r_concluido;
    assign bus.erro_cmd     = r_erro_cmd;
    assign bus.descartados  = r_descartados;

endmodule

// File: tb/tb_robo_atuador.sv
// Directed testbench for robo_atuador with hand-computed expectations.
module tb_robo_atuador;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    robo_atuador_if bus();

    robo_atuador u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive vector {frente, giro, descer, subir, garra}.
    function automatic logic [4:0] drv();
        return {bus.motor_frente, bus.motor_giro, bus.braco_descer, bus.braco_subir, bus.garra_fechar};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [4:0] col_exp [8];
    bit         drained;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        col_exp = '{5'b00100, 5'b00100, 5'b00100, 5'b00001,
                    5'b00001, 5'b00011, 5'b00011, 5'b00011};
        bus.avancar          = 1'b0;
        bus.girar            = 1'b0;
        bus.recolher_entulho = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #20;
        chk("rst_drv",  {27'd0, drv()}, 32'd0);
        chk("rst_busy", {31'd0, bus.ocupado}, 32'd0);
        chk("rst_done", {31'd0, bus.concluido}, 32'd0);
        chk("rst_err",  {31'd0, bus.erro_cmd}, 32'd0);
        chk("rst_desc", {24'd0, bus.descartados}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Idle with no commands.
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_busy", {31'd0, bus.ocupado}, 32'd0);
            chk("idle_drv",  {27'd0, drv()}, 32'd0);
        end

        // Single forward command.
        bus.avancar = 1'b1;
        tick();
        bus.avancar = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("avc_drv",  {27'd0, drv()}, 32'h10);
            chk("avc_busy", {31'd0, bus.ocupado}, 32'd1);
            chk("avc_done", {31'd0, bus.concluido}, 32'd0);
            tick();
        end
        chk("avc_end_drv",  {27'd0, drv()}, 32'd0);
        chk("avc_end_done", {31'd0, bus.concluido}, 32'd1);
        chk("avc_end_busy", {31'd0, bus.ocupado}, 32'd0);
        tick();
        chk("avc_done_pulse", {31'd0, bus.concluido}, 32'd0);

        // Collect sequence: down, grip, up.
        bus.recolher_entulho = 1'b1;
        tick();
        bus.recolher_entulho = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("col_drv",  {27'd0, drv()}, {27'd0, col_exp[i]});
            chk("col_busy", {31'd0, bus.ocupado}, 32'd1);
            tick();
        end
        chk("col_end_drv",  {27'd0, drv()}, 32'd0);
        chk("col_end_done", {31'd0, bus.concluido}, 32'd1);
        tick();

        // Simultaneous girar + avancar: error pulse, rotate wins.
        bus.girar   = 1'b1;
        bus.avancar = 1'b1;
        tick();
        bus.girar   = 1'b0;
        bus.avancar = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("err_pulse", {31'd0, bus.erro_cmd}, {31'd0, (i == 0)});
            chk("err_drv",   {27'd0, drv()}, 32'h08);
            tick();
        end
        chk("err_end_drv",  {27'd0, drv()}, 32'd0);
        chk("err_end_done", {31'd0, bus.concluido}, 32'd1);
        chk("err_end_err",  {31'd0, bus.erro_cmd}, 32'd0);
        chk("err_desc",     {24'd0, bus.descartados}, 32'd0);
        tick();

        // Rotate, then forward held through the busy window.
        bus.girar = 1'b1;
        tick();
        bus.girar   = 1'b0;
        bus.avancar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("dsc_drv", {27'd0, drv()}, 32'h08);
            tick();
        end
        chk("dsc_count", {24'd0, bus.descartados}, 32'd4);
        chk("dsc_done",  {31'd0, bus.concluido}, 32'd1);
        chk("dsc_idle",  {27'd0, drv()}, 32'd0);
        tick();
        bus.avancar = 1'b0;
        chk("dsc_acc_drv",   {27'd0, drv()}, 32'h10);
        chk("dsc_acc_count", {24'd0, bus.descartados}, 32'd4);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("dsc_avc_drv", {27'd0, drv()}, 32'h10);
        end
        tick();
        chk("dsc_avc_end", {27'd0, drv()}, 32'd0);
        chk("dsc_avc_done", {31'd0, bus.concluido}, 32'd1);

        // Saturation of the discard counter.
        bus.girar = 1'b1;
        repeat (400) tick();
        chk("sat_count", {24'd0, bus.descartados}, 32'd255);
        bus.girar = 1'b0;
        drained = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (!drained) begin
                tick();
                if (!bus.ocupado) drained = 1'b1;
            end
        end
        chk("sat_drain", {31'd0, drained}, 32'd1);
        chk("sat_hold",  {24'd0, bus.descartados}, 32'd255);
        tick();

        // Reset asserted while raising the arm.
        bus.recolher_entulho = 1'b1;
        tick();
        bus.recolher_entulho = 1'b0;
        repeat (5) tick();
        chk("sobe_drv", {27'd0, drv()}, 32'h03);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_drv",  {27'd0, drv()}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.ocupado}, 32'd0);
        chk("mid_rst_done", {31'd0, bus.concluido}, 32'd0);
        chk("mid_rst_desc", {24'd0, bus.descartados}, 32'd0);
        tick();
        chk("mid_rst_done2", {31'd0, bus.concluido}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_busy", {31'd0, bus.ocupado}, 32'd0);
            chk("post_rst_done", {31'd0, bus.concluido}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
